// File: rtl/block_ram_stream_reader.sv
// -----------------------------------------------------------------------------
// block_ram_stream_reader
//
// Streams a contiguous region of a block RAM out as a valid/ready stream.
// Reads are issued one per cycle into a small prefetch FIFO. The issue logic
// only launches a read when the FIFO is guaranteed to have room for the data,
// so downstream back-pressure never drops or overwrites a word.
//
// Optional feature (compile-time macro):
//   BLOCK_RAM_STREAM_READER_WRAP_EN - when defined, addresses wrap from
//   DATA_DEPTH-1 to 0 (circular buffer). When not defined, a start whose
//   region runs past the end of the RAM is rejected with an error pulse.
//
// Parameters:
//   DATA_WIDTH   - RAM word / stream data width
//   DATA_DEPTH   - RAM word count (ADDR_W = $clog2(DATA_DEPTH))
//   READ_LATENCY - RAM cycles from ram_read_address to ram_read_data (1 or 2)
//
// Ports:
//   clock, reset_n        - rising-edge clock, asynchronous active-low reset
//   start                 - one-cycle request to stream a region (IDLE only)
//   start_address, length - region first word and word count (0..DATA_DEPTH)
//   ram_read_address      - RAM read address (holds last issued value)
//   ram_read_data         - RAM read data
//   stream_data/valid/last, stream_ready - output stream handshake
//   busy                  - transfer in progress
//   done                  - one-cycle pulse when a transfer completes
//   error                 - one-cycle pulse when a start is rejected
// -----------------------------------------------------------------------------
module block_ram_stream_reader #(
    parameter int DATA_WIDTH   = 16,
    parameter int DATA_DEPTH   = 4096,
    parameter int READ_LATENCY = 2,
    localparam int ADDR_W      = $clog2(DATA_DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_address,
    input  logic [ADDR_W:0]       length,
    output logic [ADDR_W-1:0]     ram_read_address,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic [DATA_WIDTH-1:0] stream_data,
    output logic                  stream_valid,
    output logic                  stream_last,
    input  logic                  stream_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int FIFO_DEPTH = READ_LATENCY + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_DEPTH - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]    FIFO_CAP  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_W-1:0]       issue_addr_reg, issue_addr_next;
    logic [ADDR_W-1:0]       addr_hold_reg;
    logic [ADDR_W:0]         remaining_reg, remaining_next;
    logic [READ_LATENCY-1:0] inflight_valid_reg;
    logic [READ_LATENCY-1:0] inflight_last_reg;
    logic [DATA_WIDTH-1:0]   fifo_data_reg [FIFO_DEPTH];
    logic                    fifo_last_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]        count_reg;
    logic                    done_reg, error_reg;

    logic              range_ok;
    logic              issue_fire, issue_last;
    logic [ADDR_W-1:0] issue_addr_sel;
    logic              start_zero, start_reject;
    logic              push, push_last, pop, pop_last;
    logic              credit;
    logic [CNT_W:0]    pending;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

`ifdef BLOCK_RAM_STREAM_READER_WRAP_EN
    assign range_ok = 1'b1;
`else
    localparam logic [ADDR_W+1:0] DEPTH_EXT = (ADDR_W + 2)'(DATA_DEPTH);
    logic [ADDR_W+1:0] region_end;
    assign region_end = {2'b00, start_address} + {1'b0, length};
    assign range_ok   = (region_end <= DEPTH_EXT);
`endif

    // Stream side: the FIFO head is the output word.
    assign stream_valid = (count_reg != '0);
    assign stream_data  = fifo_data_reg[rd_ptr_reg];
    assign stream_last  = stream_valid & fifo_last_reg[rd_ptr_reg];
    assign pop          = stream_valid & stream_ready;
    assign pop_last     = pop & stream_last;

    // RAM data arrives when the oldest in-flight stage is valid.
    assign push      = inflight_valid_reg[READ_LATENCY-1];
    assign push_last = inflight_last_reg[READ_LATENCY-1];

    // Reads still in the RAM pipeline already own a FIFO slot.
    always_comb begin
        pending = {1'b0, count_reg};
        for (int i = 0; i < READ_LATENCY; i++) begin
            pending = pending + {{CNT_W{1'b0}}, inflight_valid_reg[i]};
        end
    end
    assign credit = (pending < FIFO_CAP);

    always_comb begin
        state_next      = state_reg;
        issue_addr_next = issue_addr_reg;
        remaining_next  = remaining_reg;
        issue_fire      = 1'b0;
        issue_last      = 1'b0;
        issue_addr_sel  = issue_addr_reg;
        start_zero      = 1'b0;
        start_reject    = 1'b0;
        case (state_reg)
            IDLE: begin
                // The first read goes out in the start cycle itself, which is
                // what gives a first word READ_LATENCY+1 cycles after start.
                // The FIFO and RAM pipeline are always empty in IDLE. The
                // reset_n gate keeps the address at 0 while reset is held.
                if (start && reset_n) begin
                    if (length == '0) begin
                        start_zero = 1'b1;
                    end else if (!range_ok) begin
                        start_reject = 1'b1;
                    end else begin
                        issue_fire      = 1'b1;
                        issue_addr_sel  = start_address;
                        issue_last      = (length == LEN_ONE);
                        issue_addr_next = next_addr(start_address);
                        remaining_next  = length - 1'b1;
                        state_next      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (remaining_reg == '0) begin
                    state_next = DRAIN;
                end else if (credit) begin
                    issue_fire      = 1'b1;
                    issue_last      = (remaining_reg == LEN_ONE);
                    issue_addr_next = next_addr(issue_addr_reg);
                    remaining_next  = remaining_reg - 1'b1;
                    if (remaining_reg == LEN_ONE) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ram_read_address = issue_fire ? issue_addr_sel : addr_hold_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= IDLE;
            issue_addr_reg     <= '0;
            addr_hold_reg      <= '0;
            remaining_reg      <= '0;
            inflight_valid_reg <= '0;
            inflight_last_reg  <= '0;
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            count_reg          <= '0;
            done_reg           <= 1'b0;
            error_reg          <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_reg[i] <= '0;
                fifo_last_reg[i] <= 1'b0;
            end
        end else begin
            state_reg      <= state_next;
            issue_addr_reg <= issue_addr_next;
            remaining_reg  <= remaining_next;
            if (issue_fire) begin
                addr_hold_reg <= issue_addr_sel;
            end

            inflight_valid_reg[0] <= issue_fire;
            inflight_last_reg[0]  <= issue_fire & issue_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                inflight_valid_reg[i] <= inflight_valid_reg[i-1];
                inflight_last_reg[i]  <= inflight_last_reg[i-1];
            end

            if (push) begin
                fifo_data_reg[wr_ptr_reg] <= ram_read_data;
                fifo_last_reg[wr_ptr_reg] <= push_last;
                wr_ptr_reg                <= next_ptr(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            done_reg  <= pop_last | start_zero;
            error_reg <= start_reject;
        end
    end

    assign busy  = (state_reg != IDLE);
    assign done  = done_reg;
    assign error = error_reg;

endmodule

// File: tb/tb_block_ram_stream_reader.sv
// -----------------------------------------------------------------------------
// Testbench for block_ram_stream_reader.
// Two lanes run side by side on a 16-word RAM holding RAM[i] = i:
//   lane 0 with READ_LATENCY = 1, lane 1 with READ_LATENCY = 2.
// Stimulus pushes expected words (data, last flag, handshake cycle when timing
// is fixed) into per-lane queues; a negedge monitor pops and compares on every
// handshake and also checks stall stability, done and error pulses.
// -----------------------------------------------------------------------------
module tb_block_ram_stream_reader;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [1:0]    start;
    logic [AW-1:0] start_address;
    logic [AW:0]   length;
    logic          stream_ready;

    logic [AW-1:0] rd_addr [2];
    logic [DW-1:0] rd_data [2];
    logic [DW-1:0] s_data  [2];
    logic [1:0]    s_valid, s_last, busy, done, error;

    logic [DW-1:0] ram [DEPTH];

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] prev_data  [2];
    logic          prev_last  [2];
    bit            prev_stall [2];
    int            done_due   [2];
    int            err_due    [2];
    int            hs_count   [2];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [DW-1:0] ram_q;

        block_ram_stream_reader #(
            .DATA_WIDTH  (DW),
            .DATA_DEPTH  (DEPTH),
            .READ_LATENCY(gi + 1)
        ) u_dut (
            .clock           (clock),
            .reset_n         (reset_n),
            .start           (start[gi]),
            .start_address   (start_address),
            .length          (length),
            .ram_read_address(rd_addr[gi]),
            .ram_read_data   (rd_data[gi]),
            .stream_data     (s_data[gi]),
            .stream_valid    (s_valid[gi]),
            .stream_last     (s_last[gi]),
            .stream_ready    (stream_ready),
            .busy            (busy[gi]),
            .done            (done[gi]),
            .error           (error[gi])
        );

        if (gi == 0) begin : g_l1
            always @(posedge clock) ram_q <= ram[rd_addr[gi]];
        end else begin : g_l2
            logic [DW-1:0] ram_p;
            always @(posedge clock) begin
                ram_p <= ram[rd_addr[gi]];
                ram_q <= ram_p;
            end
        end
        assign rd_data[gi] = ram_q;
    end

    task automatic check(input string name, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d actual=%0h expected=%0h cyc=%0d", name, k, act, exp, cyc);
        end
    endtask

    function automatic int q_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push_exp(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop_exp(input int k, output exp_t e, output bit got);
        got = (q_size(k) != 0);
        e.data = '0; e.last = 1'b0; e.cyc = -1;
        if (got) begin
            if (k == 0) e = q0.pop_front();
            else        e = q1.pop_front();
        end
    endtask

    task automatic monitor_lane(input int k);
        exp_t e;
        bit   got;
        if (!reset_n) begin
            prev_stall[k] = 1'b0;
            return;
        end
        if (prev_stall[k]) begin
            check("stall_valid", k, s_valid[k], 1);
            check("stall_word", k, {s_last[k], s_data[k]}, {prev_last[k], prev_data[k]});
        end
        if (s_valid[k] && stream_ready) begin
            pop_exp(k, e, got);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL unexpected_word lane%0d actual=%0h expected=none cyc=%0d", k, s_data[k], cyc);
            end else begin
                $display("lane%0d word data=%0h last=%0b cyc=%0d", k, s_data[k], s_last[k], cyc);
                if ({s_last[k], s_data[k]} !== {e.last, e.data}) begin
                    errors++;
                    $display("FAIL word lane%0d actual=%0h/%0b expected=%0h/%0b", k, s_data[k], s_last[k], e.data, e.last);
                end
                if (e.cyc >= 0) check("word_cycle", k, cyc, e.cyc);
                if (e.last) done_due[k] = cyc + 1;
                hs_count[k]++;
            end
        end
        if (done[k] || cyc == done_due[k])  check("done_pulse", k, done[k], cyc == done_due[k]);
        if (error[k] || cyc == err_due[k])  check("error_pulse", k, error[k], cyc == err_due[k]);
        prev_stall[k] = s_valid[k] && !stream_ready;
        prev_data[k]  = s_data[k];
        prev_last[k]  = s_last[k];
    endtask

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) monitor_lane(k);
    end

    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            check("rst_addr", k, rd_addr[k], 0);
            check("rst_data", k, s_data[k], 0);
            check("rst_valid", k, s_valid[k], 0);
            check("rst_last", k, s_last[k], 0);
            check("rst_busy", k, busy[k], 0);
            check("rst_done", k, done[k], 0);
            check("rst_error", k, error[k], 0);
        end
    endtask

    // Drives one start cycle and records what each selected lane must do.
    task automatic do_start(input logic [1:0] mask, input int addr, input int len,
                            input bit timed, input bit expect_err);
        int   s;
        exp_t e;
        start_address = AW'(addr);
        length        = (AW + 1)'(len);
        start         = mask;
        s             = cyc;
        $display("start mask=%0b addr=%0d len=%0d cyc=%0d", mask, addr, len, s);
        for (int k = 0; k < 2; k++) begin
            if (mask[k]) begin
                if (expect_err) begin
                    err_due[k] = s + 1;
                end else if (len == 0) begin
                    done_due[k] = s + 1;
                end else begin
                    for (int i = 0; i < len; i++) begin
                        e.data = DW'((addr + i) % DEPTH);
                        e.last = (i == len - 1);
                        e.cyc  = timed ? (s + k + 2 + i) : -1;
                        push_exp(k, e);
                    end
                end
            end
        end
        @(posedge clock); #1;
        start = 2'b00;
    endtask

    task automatic wait_idle(input bit toggle);
        bit idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            @(posedge clock); #1;
            stream_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (q_size(0) == 0 && q_size(1) == 0 && busy == 2'b00) idle = 1'b1;
        end
        check("idle_reached", 0, idle, 1);
        stream_ready = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
    endtask

    task automatic back_to_back(input int k);
        logic [1:0] m;
        bit         seen = 1'b0;
        m = 2'b00;
        m[k] = 1'b1;
        stream_ready = 1'b1;
        do_start(m, 1, 3, 1, 0);
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done[k]) seen = 1'b1;
            else begin @(posedge clock); #1; end
        end
        check("done_seen", k, seen, 1);
        do_start(m, 6, 2, 1, 0);
        wait_idle(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int h1;
        for (int k = 0; k < 2; k++) begin
            done_due[k] = -1; err_due[k] = -1; hs_count[k] = 0; prev_stall[k] = 1'b0;
        end
        reset_n = 1'b1; start = 2'b00; start_address = '0; length = '0; stream_ready = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs();
        reset_n = 1'b1;
        repeat (2) begin @(posedge clock); #1; end

        // Basic region, full throughput, exact timing.
        do_start(2'b11, 10, 4, 1, 0);
        wait_idle(0);

        // Same region under back-pressure; a start while busy must be ignored.
        do_start(2'b11, 10, 4, 0, 0);
        start = 2'b11; start_address = AW'(0); length = (AW + 1)'(2);
        @(posedge clock); #1;
        start = 2'b00;
        wait_idle(1);

        // Zero length: done next cycle, nothing streamed, never busy.
        do_start(2'b11, 5, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            check("len0_busy", k, busy[k], 0);
            check("len0_valid", k, s_valid[k], 0);
        end
        wait_idle(0);

        // Region ending exactly at the top of RAM.
        do_start(2'b11, 12, 4, 1, 0);
        wait_idle(0);

        // Region crossing the top of RAM.
`ifdef BLOCK_RAM_STREAM_READER_WRAP_EN
        do_start(2'b11, 14, 4, 1, 0);
`else
        do_start(2'b11, 14, 4, 0, 1);
        for (int k = 0; k < 2; k++) begin
            check("reject_busy", k, busy[k], 0);
            check("reject_valid", k, s_valid[k], 0);
        end
`endif
        wait_idle(0);

        // Reset in the middle of an 8-word transfer.
        h1 = hs_count[1];
        do_start(2'b11, 0, 8, 1, 0);
        repeat (4) begin @(posedge clock); #1; end
        check("words_before_reset", 1, hs_count[1] - h1, 2);
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        q0.delete(); q1.delete();
        for (int k = 0; k < 2; k++) done_due[k] = -1;
        repeat (2) begin @(posedge clock); #1; end
        reset_n = 1'b1;
        repeat (10) begin @(posedge clock); #1; end
        for (int k = 0; k < 2; k++) check("post_reset_idle", k, {busy[k], s_valid[k]}, 0);
        do_start(2'b11, 3, 3, 1, 0);
        wait_idle(0);

        // Back-to-back transfers: second start in the done cycle.
        back_to_back(0);
        back_to_back(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
